fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised successor to the program-counter logic of the 16-bit datapath: owns the PC, fetches 1- or 2-word instructions from instruction memory over a req/valid handshake, and presents whole instructions to decode over a valid/ready handshake.
- Adds behaviour the current PC path lacks: variable memory latency, a hardware return-address stack (RAS) for call/return, and stall and back-pressure handling.
- Sits between instruction memory and the decoder/datapath.

Parameters:
ADDR_WIDTH, 16, PC and instruction-memory address width
DATA_WIDTH, 16, instruction word width
RAS_DEPTH, 8, return-address stack entries (power of two, >= 2)
RESET_VECTOR, 0, PC value loaded on reset

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request; held until accepted
imem_addr  output  ADDR_WIDTH  fetch address; stable while imem_req=1
imem_rdata  input  DATA_WIDTH  fetched word; valid when imem_valid=1
imem_valid  input  1  response strobe; may assert in the same cycle as imem_req
word0_is_long  input  1  combinational predecode of imem_rdata: 1 means a 2-word instruction
instr_valid  output  1  instruction available to decode
instr_ready  input  1  decode accepts the instruction
instr_word0  output  DATA_WIDTH  first word
instr_word1  output  DATA_WIDTH  second word; 0 for short instructions
instr_long  output  1  1 means instr_word1 is meaningful
instr_pc  output  ADDR_WIDTH  address of instr_word0
redirect_valid  input  1  control-flow change tied to the instruction being accepted
redirect_kind  input  2  00 jump, 01 taken branch, 10 call, 11 return
redirect_target  input  ADDR_WIDTH  target for kinds 00/01/10; fallback target for 11
ras_count  output  clog2(RAS_DEPTH)+1  number of valid RAS entries
ras_overflow  output  1  sticky: a push occurred while the RAS was full
ras_underflow  output  1  sticky: a pop occurred while the RAS was empty

Behaviour:
Reset:
- While rst=0: state=F0, pc=RESET_VECTOR, RAS empty, ras_count=0, both sticky flags 0.
- While rst=0: imem_req=0, instr_valid=0, instr_word0/1=0, instr_long=0, instr_pc=0.
- Reset mid-transaction abandons the outstanding request. An imem_valid arriving after reset deasserts is ignored unless it answers a new request.

State F0:
- imem_req=1, imem_addr=pc.
- On imem_valid=1: capture word0, latch instr_long=word0_is_long.
- Long instruction -> F1; otherwise -> OUT with word1=0.

State F1:
- imem_req=1, imem_addr=pc+1, modulo 2^ADDR_WIDTH.
- On imem_valid=1: capture word1 -> OUT.

State OUT:
- instr_valid=1, imem_req=0; outputs stay stable until accepted.
- Accept = instr_valid & instr_ready. len = 2 if instr_long else 1.
- Accept with redirect_valid=0: pc <= pc+len (wraps) -> F0.
- Accept with jump or taken branch: pc <= redirect_target -> F0.
- Accept with call: push pc+len onto the RAS; pc <= redirect_target -> F0.
  - If the RAS is full: overwrite the oldest entry (circular), ras_count stays RAS_DEPTH, set ras_overflow.
- Accept with return and RAS non-empty: pc <= popped top entry, ras_count-1 -> F0.
- Accept with return and RAS empty: pc <= redirect_target, set ras_underflow, count stays 0.

Other rules:
- redirect_valid is ignored when no accept occurs.
- Exactly one push or pop per accept.
- Throughput with zero-wait memory: short instruction = 2 cycles (F0, OUT); long = 3 cycles.
- Each extra memory wait cycle adds one cycle.
- Sticky flags clear only on reset.

Test Plan:
- Reset release, RESET_VECTOR=0x0100, zero-wait memory, all short, instr_ready=1 -> instr_pc 0x0100, 0x0101, 0x0102 on every second cycle; first imem_req in the cycle after rst rises.
- Long instruction at 0x0010 (word0 0xA000, word1 0x1234) with 3-cycle memory latency -> imem_addr held at 0x0010 then 0x0011; instr_long=1, word1=0x1234; next fetch at 0x0012.
- instr_ready low for 5 cycles in OUT -> all instr_* outputs stable and imem_req=0; on accept, next fetch issued the following cycle.
- Call at pc=0x0020 (short) to 0x0400, then return at 0x0405 -> ras_count 1 then 0; fetches 0x0400 then 0x0021.
- RAS_DEPTH=4: five nested calls then five returns -> ras_overflow=1 after call 5; returns 1-4 pop the 4 most recent addresses; return 5 sets ras_underflow and jumps to its redirect_target.
- Wrap: ADDR_WIDTH=16, long instruction at 0xFFFF -> word1 fetched from 0x0000; next pc 0x0001. Assert rst mid-F1 -> outputs return to reset values immediately and the fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch unit: owns the PC, fetches 1/2-word instructions over req/valid, hands them to decode over valid/ready.
// Zero-wait latency 2 cycles (short) / 3 (long); instruction held stable in OUT until decode accepts it.
module fetch_unit #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    RAS_DEPTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imem_req,
    output logic [ADDR_WIDTH-1:0]         imem_addr,
    input  logic [DATA_WIDTH-1:0]         imem_rdata,
    input  logic                          imem_valid,
    input  logic                          word0_is_long,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [DATA_WIDTH-1:0]         instr_word0,
    output logic [DATA_WIDTH-1:0]         instr_word1,
    output logic                          instr_long,
    output logic [ADDR_WIDTH-1:0]         instr_pc,
    input  logic                          redirect_valid,
    input  logic [1:0]                    redirect_kind,
    input  logic [ADDR_WIDTH-1:0]         redirect_target,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_overflow,
    output logic                          ras_underflow
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_F0, S_F1, S_OUT} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_imem_req;
    logic                  r_instr_valid;
    logic [DATA_WIDTH-1:0] r_word0;
    logic [DATA_WIDTH-1:0] r_word1;
    logic                  r_long;
    logic [ADDR_WIDTH-1:0] r_instr_pc;
    logic [ADDR_WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]         r_ras_wp;
    logic [CW-1:0]         r_ras_count;
    logic                  r_ras_overflow;
    logic                  r_ras_underflow;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [PW-1:0]         w_top_idx;
    logic [ADDR_WIDTH-1:0] w_seq_pc;
    logic [ADDR_WIDTH-1:0] w_next_pc;

    assign w_accept  = r_instr_valid & instr_ready;
    assign w_push    = w_accept & redirect_valid & (redirect_kind == 2'b10);
    assign w_pop     = w_accept & redirect_valid & (redirect_kind == 2'b11);
    assign w_full    = (r_ras_count == CW'(RAS_DEPTH));
    assign w_empty   = (r_ras_count == '0);
    assign w_top_idx = r_ras_wp - PW'(1);
    assign w_seq_pc  = r_pc + (r_long ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));

    always_comb begin
        w_next_pc = w_seq_pc;
        if (redirect_valid) begin
            if (redirect_kind == 2'b11 && !w_empty)
                w_next_pc = r_ras[w_top_idx];
            else
                w_next_pc = redirect_target;
        end
    end

    // Write pointer always points at the slot after the top; when full that slot is the oldest entry.
    always_ff @(posedge clk) begin
        if (w_push)
            r_ras[r_ras_wp] <= w_seq_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_F0;
            r_pc            <= RESET_VECTOR;
            r_imem_req      <= 1'b0;
            r_instr_valid   <= 1'b0;
            r_word0         <= '0;
            r_word1         <= '0;
            r_long          <= 1'b0;
            r_instr_pc      <= '0;
            r_ras_wp        <= '0;
            r_ras_count     <= '0;
            r_ras_overflow  <= 1'b0;
            r_ras_underflow <= 1'b0;
        end else begin
            case (r_state)
                S_F0: begin
                    // A response only counts while our request is actually up.
                    if (r_imem_req && imem_valid) begin
                        r_word0    <= imem_rdata;
                        r_word1    <= '0;
                        r_long     <= word0_is_long;
                        r_instr_pc <= r_pc;
                        if (word0_is_long) begin
                            r_state <= S_F1;
                        end else begin
                            r_state       <= S_OUT;
                            r_imem_req    <= 1'b0;
                            r_instr_valid <= 1'b1;
                        end
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                S_F1: begin
                    if (r_imem_req && imem_valid) begin
                        r_word1       <= imem_rdata;
                        r_state       <= S_OUT;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (w_accept) begin
                        r_state       <= S_F0;
                        r_imem_req    <= 1'b1;
                        r_instr_valid <= 1'b0;
                        r_pc          <= w_next_pc;
                        if (w_push) begin
                            r_ras_wp <= r_ras_wp + PW'(1);
                            if (w_full)
                                r_ras_overflow <= 1'b1;
                            else
                                r_ras_count <= r_ras_count + CW'(1);
                        end
                        if (w_pop) begin
                            if (w_empty) begin
                                r_ras_underflow <= 1'b1;
                            end else begin
                                r_ras_wp    <= w_top_idx;
                                r_ras_count <= r_ras_count - CW'(1);
                            end
                        end
                    end
                end
                default: r_state <= S_F0;
            endcase
        end
    end

    assign imem_req      = r_imem_req;
    assign imem_addr     = (r_state == S_F1) ? r_pc + ADDR_WIDTH'(1) : r_pc;
    assign instr_valid   = r_instr_valid;
    assign instr_word0   = r_word0;
    assign instr_word1   = r_word1;
    assign instr_long    = r_long;
    assign instr_pc      = r_instr_pc;
    assign ras_count     = r_ras_count;
    assign ras_overflow  = r_ras_overflow;
    assign ras_underflow = r_ras_underflow;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with programmable wait cycles, hand-computed expectations.
module tb_fetch_unit;
    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        word0_is_long;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_word0;
    logic [15:0] instr_word1;
    logic        instr_long;
    logic [15:0] instr_pc;
    logic        redirect_valid;
    logic [1:0]  redirect_kind;
    logic [15:0] redirect_target;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks = 0;
    int errors = 0;
    int lat    = 0;
    int wait_cnt;

    logic [15:0] mem [0:65535];

    logic [15:0] call_tgt [5];
    logic [2:0]  call_cnt [5];
    logic        call_ovf [5];
    logic [15:0] ret_pc   [4];
    logic [2:0]  ret_cnt  [4];

    fetch_unit #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (16),
        .RAS_DEPTH   (4),
        .RESET_VECTOR(16'h0100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_valid     (imem_valid),
        .word0_is_long  (word0_is_long),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_word0    (instr_word0),
        .instr_word1    (instr_word1),
        .instr_long     (instr_long),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_kind  (redirect_kind),
        .redirect_target(redirect_target),
        .ras_count      (ras_count),
        .ras_overflow   (ras_overflow),
        .ras_underflow  (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata    = mem[imem_addr];
    assign word0_is_long = imem_rdata[15];
    assign imem_valid    = imem_req && (wait_cnt >= lat);

    always_ff @(posedge clk) begin
        if (!imem_req || imem_valid)
            wait_cnt <= 0;
        else
            wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_accept(input logic rv, input logic [1:0] kind, input logic [15:0] tgt);
        instr_ready     = 1'b1;
        redirect_valid  = rv;
        redirect_kind   = kind;
        redirect_target = tgt;
        @(negedge clk);
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_instr(input string tag, input logic [15:0] exp_pc);
        int n = 0;
        while (!instr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {instr_valid, instr_pc}, {1'b1, exp_pc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a) & 16'h7FFF;
        mem[16'h0010] = 16'hA000;
        mem[16'h0011] = 16'h1234;
        mem[16'hFFFF] = 16'h8001;
        mem[16'h0000] = 16'h5555;
        call_tgt = '{16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600};
        call_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        call_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ret_pc   = '{16'h0501, 16'h0401, 16'h0301, 16'h0201};
        ret_cnt  = '{3'd3, 3'd2, 3'd1, 3'd0};

        rst             = 1'b0;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_kind   = 2'b00;
        redirect_target = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_outs", {imem_req, instr_valid, instr_long, instr_pc, instr_word0, instr_word1}, 64'h0);
        chk("reset_ras", {ras_count, ras_overflow, ras_underflow}, 64'h0);

        // Reset release and zero-wait short-instruction throughput
        rst = 1'b1;
        #1;
        chk("req_low_at_release", imem_req, 1'b0);
        @(negedge clk);
        chk("first_req", {imem_req, imem_addr}, {1'b1, 16'h0100});
        @(negedge clk);
        chk("instr_0100", {instr_valid, instr_pc, instr_word0}, {1'b1, 16'h0100, 16'h0100});
        @(negedge clk);
        chk("gap_0", instr_valid, 1'b0);
        @(negedge clk);
        chk("instr_0101", {instr_valid, instr_pc}, {1'b1, 16'h0101});
        @(negedge clk);
        chk("gap_1", instr_valid, 1'b0);
        @(negedge clk);
        chk("instr_0102", {instr_valid, instr_pc}, {1'b1, 16'h0102});
        instr_ready = 1'b0;

        // Back-pressure: outputs frozen, no fetch
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_stable", {instr_valid, imem_req, instr_long, instr_pc, instr_word0, instr_word1},
                {1'b1, 1'b0, 1'b0, 16'h0102, 16'h0102, 16'h0000});
        end

        // Long instruction with 3 wait cycles
        lat = 3;
        do_accept(1'b1, 2'b00, 16'h0010);
        for (int i = 0; i < 4; i++) begin
            chk("long_addr_w0", {imem_req, imem_addr}, {1'b1, 16'h0010});
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            chk("long_addr_w1", {imem_req, imem_addr}, {1'b1, 16'h0011});
            @(negedge clk);
        end
        chk("long_instr", {instr_valid, instr_long, instr_pc, instr_word0, instr_word1},
            {1'b1, 1'b1, 16'h0010, 16'hA000, 16'h1234});
        lat = 0;
        do_accept(1'b0, 2'b00, 16'h0000);
        chk("after_long_fetch", {imem_req, imem_addr}, {1'b1, 16'h0012});
        wait_instr("instr_0012", 16'h0012);

        // Single call / return
        do_accept(1'b1, 2'b00, 16'h0020);
        wait_instr("instr_0020", 16'h0020);
        do_accept(1'b1, 2'b10, 16'h0400);
        chk("call_count", ras_count, 3'd1);
        wait_instr("call_target", 16'h0400);
        do_accept(1'b1, 2'b00, 16'h0405);
        wait_instr("instr_0405", 16'h0405);
        do_accept(1'b1, 2'b11, 16'h0777);
        chk("ret_count", ras_count, 3'd0);
        wait_instr("ret_target", 16'h0021);

        // Nested calls past RAS depth, then unwind past empty
        for (int i = 0; i < 5; i++) begin
            do_accept(1'b1, 2'b10, call_tgt[i]);
            chk("nest_call_count", ras_count, call_cnt[i]);
            chk("nest_call_ovf", ras_overflow, call_ovf[i]);
            wait_instr("nest_call_pc", call_tgt[i]);
        end
        for (int i = 0; i < 4; i++) begin
            do_accept(1'b1, 2'b11, 16'h0F00);
            chk("nest_ret_count", ras_count, ret_cnt[i]);
            wait_instr("nest_ret_pc", ret_pc[i]);
        end
        chk("underflow_before", ras_underflow, 1'b0);
        do_accept(1'b1, 2'b11, 16'h0ABC);
        chk("underflow_after", {ras_underflow, ras_overflow, ras_count}, {1'b1, 1'b1, 3'd0});
        wait_instr("underflow_pc", 16'h0ABC);

        // Address wrap on a long instruction at the top of memory
        do_accept(1'b1, 2'b00, 16'hFFFF);
        @(negedge clk);
        chk("wrap_word1_addr", {imem_req, imem_addr}, {1'b1, 16'h0000});
        wait_instr("wrap_pc", 16'hFFFF);
        chk("wrap_instr", {instr_long, instr_word0, instr_word1}, {1'b1, 16'h8001, 16'h5555});
        do_accept(1'b0, 2'b00, 16'h0000);
        chk("wrap_next_addr", {imem_req, imem_addr}, {1'b1, 16'h0001});
        wait_instr("wrap_next_pc", 16'h0001);

        // Reset asserted while waiting on the second word
        lat = 3;
        do_accept(1'b1, 2'b00, 16'h0010);
        repeat (4) @(negedge clk);
        chk("in_f1", {imem_req, imem_addr}, {1'b1, 16'h0011});
        rst = 1'b0;
        #1;
        chk("midf1_reset_outs", {imem_req, instr_valid, instr_long, instr_pc, instr_word0, instr_word1}, 64'h0);
        chk("midf1_reset_ras", {ras_count, ras_overflow, ras_underflow}, 64'h0);
        repeat (2) @(negedge clk);
        lat = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("restart_addr", {imem_req, imem_addr}, {1'b1, 16'h0100});
        wait_instr("restart_pc", 16'h0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
